// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the divider requester front end.
//   - default widths and timeout budget
//   - response status codes
//   - requester FSM state encoding
package div_pkg;

  localparam int DW_DEF      = 10;  // dividend width
  localparam int QW_DEF      = 5;   // divisor / quotient / remainder width
  localparam int TIMEOUT_DEF = 63;  // cycles allowed from div_start to final divider event

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_DB0 = 2'b01,
    ST_OV  = 2'b10,
    ST_TO  = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT_Q = 3'd2,
    S_WAIT_R = 3'd3,
    S_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/div_timeout_ctr.sv
// div_timeout_ctr: saturating cycle counter with terminal-count flag.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-low reset
//   clr  in  synchronous clear (wins over en)
//   en   in  count enable
//   tc   out high while count equals LIMIT
// The count stops at LIMIT so a long wait can never wrap back to a small value.
module div_timeout_ctr #(
  parameter int LIMIT = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != W'(LIMIT))) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(LIMIT));

endmodule

// File: rtl/div_requester.sv
// div_requester: initiator-side front end for the shift/subtract divider.
// Accepts one request, holds the operands for the divider, pulses div_start,
// collects quotient then remainder from the shared div_out bus and returns
// a single response with status. One request outstanding at a time.
// Ports:
//   clk, rst                 clock / asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_dividend/req_divisor request operands
//   div_start                one-cycle start pulse to the divider
//   div_dividend/div_divisor operands held from accept until next accept
//   div_out, div_doneq, div_donew, div_by0, div_ov   divider results/flags
//   rsp_valid/rsp_ready      response handshake
//   rsp_quotient/rsp_remainder/rsp_status            response payload
module div_requester
  import div_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int QW      = QW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] req_dividend,
  input  logic [QW-1:0] req_divisor,
  output logic          div_start,
  output logic [DW-1:0] div_dividend,
  output logic [QW-1:0] div_divisor,
  input  logic [QW-1:0] div_out,
  input  logic          div_doneq,
  input  logic          div_donew,
  input  logic          div_by0,
  input  logic          div_ov,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [QW-1:0] rsp_quotient,
  output logic [QW-1:0] rsp_remainder,
  output logic [1:0]    rsp_status
);

  state_e state;
  logic   tmr_clr;
  logic   tmr_en;
  logic   tmr_tc;

  // Handshake/strobe outputs are straight decodes of the state register.
  assign req_ready = (state == S_IDLE);
  assign div_start = (state == S_START);
  assign rsp_valid = (state == S_RESP);

  // Timer runs across both wait states, so the budget covers the whole
  // divider operation measured from div_start, not each phase separately.
  assign tmr_clr = (state == S_START);
  assign tmr_en  = (state == S_WAIT_Q) || (state == S_WAIT_R);

  div_timeout_ctr #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      div_dividend  <= '0;
      div_divisor   <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_status    <= ST_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            div_dividend <= req_dividend;
            div_divisor  <= req_divisor;
            state        <= S_START;
          end
        end
        S_START: begin
          state <= S_WAIT_Q;
        end
        S_WAIT_Q: begin
          // Error flags outrank a quotient in the same cycle; donew is ignored here.
          if (div_by0) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_status    <= ST_DB0;
            state         <= S_RESP;
          end else if (div_ov) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_status    <= ST_OV;
            state         <= S_RESP;
          end else if (div_doneq) begin
            rsp_quotient <= div_out;
            state        <= S_WAIT_R;
          end else if (tmr_tc) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_status    <= ST_TO;
            state         <= S_RESP;
          end
        end
        S_WAIT_R: begin
          // A remainder arriving on the terminal cycle still completes normally.
          if (div_donew) begin
            rsp_remainder <= div_out;
            rsp_status    <= ST_OK;
            state         <= S_RESP;
          end else if (tmr_tc) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_status    <= ST_TO;
            state         <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
